fetch_stage: RTL and testbench

- Instruction-fetch stage of the five-stage MIPS pipeline.
- Holds the program counter and drives the combinational instruction memory address.
- Captures the returned instruction plus PC+4 into the IF/ID pipeline register.
- Handles load-use stalls from the hazard unit and branch/jump redirects resolved in ID, and keeps a retired-fetch counter for debug.

---
 rtl/fetch_stage.sv | 75 +++++++
 tb/tb_fetch_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC, IF/ID register, stall/redirect, fetch counter
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_target,
    output logic [31:0]            im_address,
    input  logic [31:0]            im_instruction,
    output logic [31:0]            pc,
    output logic [31:0]            if_id_instruction,
    output logic [31:0]            if_id_pc_plus4,
    output logic                   if_id_valid,
    output logic [COUNT_WIDTH-1:0] fetch_count
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0]            pc_q, pc_d;
    logic [31:0]            instr_q, instr_d;
    logic [31:0]            pp4_q, pp4_d;
    logic                   valid_q, valid_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [31:0]            pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // Redirect beats stall: a taken branch must squash the wrong-path fetch even when ID is held.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pp4_d   = pp4_q;
        valid_d = valid_q;
        count_d = count_q;
        if (redirect) begin
            pc_d    = {redirect_target[31:2], 2'b00};
            instr_d = 32'h0000_0000;
            pp4_d   = 32'h0000_0000;
            valid_d = 1'b0;
        end else if (!stall) begin
            pc_d    = pc_plus4;
            instr_d = im_instruction;
            pp4_d   = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC_ALIGNED;
            instr_q <= 32'h0000_0000;
            pp4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pp4_q   <= pp4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign im_address        = pc_q;
    assign pc                = pc_q;
    assign if_id_instruction = instr_q;
    assign if_id_pc_plus4    = pp4_q;
    assign if_id_valid       = valid_q;
    assign fetch_count       = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage against a behavioural model
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] im_address;
    logic [31:0] im_instruction;
    logic [31:0] pc;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int n_vec = 0;
    int n_err = 0;
    logic rand_mem = 1'b0;

    logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
    logic        m_valid;

    fetch_stage #(.RESET_PC(32'h0000_0000), .COUNT_WIDTH(32)) dut (
        .clock             (clock),
        .reset             (reset),
        .stall             (stall),
        .redirect          (redirect),
        .redirect_target   (redirect_target),
        .im_address        (im_address),
        .im_instruction    (im_instruction),
        .pc                (pc),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_valid       (if_id_valid),
        .fetch_count       (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word k of the directed image is 32'h1000_0000+k; the top word is a fixed marker for the wrap test.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'hFFFF_FFFC) return 32'hABCD_0001;
        if (rand_mem)              return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    always_comb im_instruction = mem_word(im_address);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    pc, m_pc);
        check({tag, ".addr"},  im_address, m_pc);
        check({tag, ".instr"}, if_id_instruction, m_instr);
        check({tag, ".pp4"},   if_id_pc_plus4, m_pp4);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
        check({tag, ".count"}, fetch_count, m_cnt);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic step(input string tag, input logic s, input logic r, input logic [31:0] t);
        logic [31:0] word;
        stall = s; redirect = r; redirect_target = t;
        word = mem_word(m_pc);
        @(posedge clock);
        if (r) begin
            m_pc = t & 32'hFFFF_FFFC;
            m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
        end else if (!s) begin
            m_instr = word;
            m_pp4   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
        end
        #1 check_all(tag);
    endtask

    // Reset is raised between edges and checked before any further edge arrives.
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all(tag);
        @(negedge clock) reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 check_all("reset");
        @(negedge clock) reset = 1'b0;

        for (int k = 0; k < 4; k++) step("seq", 1'b0, 1'b0, 32'h0);
        check("seq.pc_end", pc, 32'd16);
        check("seq.count_end", fetch_count, 32'd4);
        check("seq.last_word", if_id_instruction, 32'h1000_0003);

        async_reset("rst2");
        step("st.pre", 1'b0, 1'b0, 32'h0);
        step("st.pre", 1'b0, 1'b0, 32'h0);
        check("st.pc8", pc, 32'd8);
        for (int k = 0; k < 3; k++) begin
            step("st.hold", 1'b1, 1'b0, 32'h0);
            check("st.hold_word", if_id_instruction, 32'h1000_0001);
            check("st.hold_pp4", if_id_pc_plus4, 32'd8);
        end
        step("st.rel", 1'b0, 1'b0, 32'h0);
        check("st.rel_word", if_id_instruction, 32'h1000_0002);
        check("st.rel_pc", pc, 32'd12);

        step("rd", 1'b0, 1'b1, 32'h0000_0023);
        check("rd.pc", pc, 32'h20);
        check("rd.valid", {31'd0, if_id_valid}, 32'd0);
        step("rd.next", 1'b0, 1'b0, 32'h0);
        check("rd.word8", if_id_instruction, 32'h1000_0008);
        check("rd.pp4", if_id_pc_plus4, 32'h24);

        step("rdst", 1'b1, 1'b1, 32'h0000_0040);
        check("rdst.pc", pc, 32'h40);
        check("rdst.instr", if_id_instruction, 32'h0);

        step("ar.pre", 1'b0, 1'b1, 32'h0000_0018);
        async_reset("ar");
        check("ar.pc", pc, 32'h0);
        step("ar.post", 1'b0, 1'b0, 32'h0);
        check("ar.word0", if_id_instruction, 32'h1000_0000);

        step("wrap.rd", 1'b0, 1'b1, 32'hFFFF_FFFC);
        step("wrap", 1'b0, 1'b0, 32'h0);
        check("wrap.pc", pc, 32'h0);
        check("wrap.pp4", if_id_pc_plus4, 32'h0);
        check("wrap.instr", if_id_instruction, 32'hABCD_0001);

        rand_mem = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic s, r;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 7) == 0);
            t = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            if ($urandom_range(0, 59) == 0) async_reset("rnd.rst");
            else step("rnd", s, r, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
